// File: rtl/weight_ram_stream_if.sv
// weight_ram_stream_if
//   Bundles the loader write port, the stream request/status signals and the
//   valid/ready weight stream of weight_ram_stream.
//
//   Write port : we_w, addrw, dw
//   Request    : rd_start, rd_base, rd_count (in), rd_busy, rd_done (out)
//   Stream     : w_valid, w_data, w_last (out), w_ready (in)
//
//   modport slave  : the weight RAM itself
//   modport master : the loader / convolution engine side driving it
interface weight_ram_stream_if #(
    parameter int SIZE_12          = 132,
    parameter int SIZE_address_wei = 9
);
    logic                        we_w;
    logic [SIZE_address_wei-1:0] addrw;
    logic [SIZE_12-1:0]          dw;

    logic                        rd_start;
    logic [SIZE_address_wei-1:0] rd_base;
    logic [SIZE_address_wei:0]   rd_count;
    logic                        rd_busy;
    logic                        rd_done;

    logic                        w_valid;
    logic                        w_ready;
    logic [SIZE_12-1:0]          w_data;
    logic                        w_last;

    modport master (
        output we_w, addrw, dw, rd_start, rd_base, rd_count, w_ready,
        input  rd_busy, rd_done, w_valid, w_data, w_last
    );

    modport slave (
        input  we_w, addrw, dw, rd_start, rd_base, rd_count, w_ready,
        output rd_busy, rd_done, w_valid, w_data, w_last
    );
endinterface

// File: rtl/weight_ram_stream.sv
// weight_ram_stream
//   Weight storage stage behind the pixel/weight loader. The loader writes
//   packed weight words (one 3x3 depthwise kernel or up to 12 pointwise
//   weights per word); on rd_start the block streams rd_count words starting
//   at rd_base through a valid/ready handshake, one word per cycle when the
//   consumer keeps w_ready high.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset (RAM contents are kept)
//     bus    - weight_ram_stream_if.slave: loader write port, stream
//              request/status and the weight stream itself
//
//   Build option:
//     WEIGHT_RAM_WR_BYPASS_EN - when defined, a read that hits the address
//     being written in the same cycle returns the new word (write-first).
//     Undefined: read-first, the old word is returned.
module weight_ram_stream #(
    parameter int SIZE_1           = 11,
    parameter int SIZE_12          = 132,
    parameter int SIZE_address_wei = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    weight_ram_stream_if.slave    bus
);

    localparam int DEPTH = 1 << SIZE_address_wei;
    localparam int CW    = SIZE_address_wei + 1;

    localparam logic [SIZE_address_wei-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0]               CNT_ONE = 1;

    if (SIZE_12 != 12 * SIZE_1) begin : g_bad_width
        $error("weight_ram_stream: SIZE_12 must equal 12*SIZE_1");
    end

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    state_t                      state;
    logic [SIZE_address_wei-1:0] rd_ptr;
    logic [CW-1:0]               issue_left;
    logic [CW-1:0]               out_left;
    logic                        rd_busy_q;
    logic                        rd_done_q;

    logic [SIZE_12-1:0]          mem [DEPTH];
    logic [SIZE_12-1:0]          rd_word;

    // The 2-entry output FIFO is the RAM output register (q_*) plus one skid
    // register. The skid entry, when valid, is always the older word.
    logic [SIZE_12-1:0]          q_data;
    logic                        q_valid;
    logic [SIZE_12-1:0]          skid_data;
    logic                        skid_valid;

    logic                        fifo_full;
    logic                        w_valid_c;
    logic                        pop;
    logic                        issue;

    assign fifo_full = skid_valid & q_valid;
    assign w_valid_c = skid_valid | q_valid;
    assign pop       = w_valid_c & bus.w_ready;
    // Read data lands in the FIFO on the same edge it is issued, so nothing
    // is ever in flight between edges; occupancy alone gates issue.
    assign issue     = (state == STREAM) && (issue_left != '0) && !fifo_full;

    always_comb begin
        rd_word = mem[rd_ptr];
`ifdef WEIGHT_RAM_WR_BYPASS_EN
        if (bus.we_w && (bus.addrw == rd_ptr)) begin
            rd_word = bus.dw;
        end
`endif
    end

    // RAM array and its registered read port; deliberately not reset so it
    // maps onto block RAM.
    always_ff @(posedge clk) begin
        if (bus.we_w) begin
            mem[bus.addrw] <= bus.dw;
        end
        if (issue) begin
            q_data <= rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            issue_left <= '0;
            out_left   <= '0;
            rd_busy_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            q_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rd_done_q <= 1'b0;
                    if (bus.rd_start) begin
                        rd_ptr     <= bus.rd_base;
                        issue_left <= bus.rd_count;
                        out_left   <= bus.rd_count;
                        if (bus.rd_count == '0) begin
                            state     <= FINISH;
                            rd_done_q <= 1'b1;
                        end else begin
                            state     <= STREAM;
                            rd_busy_q <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (issue) begin
                        rd_ptr     <= rd_ptr + PTR_ONE;
                        issue_left <= issue_left - CNT_ONE;
                    end
                    if (pop) begin
                        out_left <= out_left - CNT_ONE;
                        if (out_left == CNT_ONE) begin
                            state     <= FINISH;
                            rd_busy_q <= 1'b0;
                            rd_done_q <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    rd_done_q <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // FIFO bookkeeping. Issue is only allowed when at most one entry
            // is valid; if the RAM register still holds an unconsumed word it
            // moves to the skid slot before being overwritten.
            if (pop) begin
                if (skid_valid) begin
                    skid_valid <= 1'b0;
                end else begin
                    q_valid <= 1'b0;
                end
            end
            if (issue) begin
                if (q_valid && !pop) begin
                    skid_data  <= q_data;
                    skid_valid <= 1'b1;
                end
                q_valid <= 1'b1;
            end
        end
    end

    assign bus.rd_busy = rd_busy_q;
    assign bus.rd_done = rd_done_q;
    assign bus.w_valid = w_valid_c;
    assign bus.w_data  = skid_valid ? skid_data : (q_valid ? q_data : '0);
    assign bus.w_last  = w_valid_c && (out_left == CNT_ONE);

endmodule

// File: tb/tb_weight_ram_stream.sv
// tb_weight_ram_stream
//   Self-checking bench for weight_ram_stream. A plain array mirrors the RAM
//   contents; each stream's expected words are taken from it in address order
//   (modulo depth) and compared against the handshakes the DUT produces.
//   Honours WEIGHT_RAM_WR_BYPASS_EN for the read-during-write expectation.
module tb_weight_ram_stream;

    localparam int W     = 132;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] model [DEPTH];

    weight_ram_stream_if #(.SIZE_12(W), .SIZE_address_wei(AW)) bus ();

    weight_ram_stream #(
        .SIZE_1(11), .SIZE_12(W), .SIZE_address_wei(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] randWord();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) r = {r[W-33:0], 32'($urandom)};
        return r;
    endfunction

    // One loader write cycle; called at a negedge, returns at the next one.
    task automatic applyStimulus(input int addr, input logic [W-1:0] data);
        bus.we_w  = 1'b1;
        bus.addrw = AW'(addr);
        bus.dw    = data;
        model[addr % DEPTH] = data;
        @(posedge clk);
        @(negedge clk);
        bus.we_w  = 1'b0;
    endtask

    // Runs one stream and checks it. mode: 0 ready high, 1 ready 1,0,0..,
    // 2 random ready. interruptIdx: cycle to pulse a stray rd_start.
    // abortAfter: reset after that many handshakes. wrMode: 1 write rd_base
    // together with rd_start, 2 write rd_base in the first issue cycle.
    task automatic runStream(input int base, input int count, input int mode,
                             input int interruptIdx, input int abortAfter,
                             input int wrMode, input string tag);
        logic [W-1:0] expq[$];
        logic [W-1:0] newWord, data, prevData, expWord;
        logic         valid, last, ready, prevLast, prevStall, finished;
        int           idx, hs, firstValid, lastHs, doneIdx, doneCnt, maxCycles;

        newWord = randWord();
        hs = 0; firstValid = -1; lastHs = -1; doneIdx = -1; doneCnt = 0;
        prevStall = 1'b0; prevData = '0; prevLast = 1'b0; finished = 1'b0;
        maxCycles = 4 * count + 20;

        if (wrMode == 1) begin
            bus.we_w = 1'b1; bus.addrw = AW'(base); bus.dw = newWord;
            model[base] = newWord;
        end
        bus.rd_start = 1'b1;
        bus.rd_base  = AW'(base);
        bus.rd_count = (AW + 1)'(count);
        for (int i = 0; i < count; i++) expq.push_back(model[(base + i) % DEPTH]);
        @(posedge clk);
        @(negedge clk);
        bus.rd_start = 1'b0;
        bus.we_w     = 1'b0;
        if (wrMode == 2) begin
            bus.we_w = 1'b1; bus.addrw = AW'(base); bus.dw = newWord;
            model[base] = newWord;
`ifdef WEIGHT_RAM_WR_BYPASS_EN
            expq[0] = newWord;
`endif
        end

        idx = 1;
        while (!finished && idx <= maxCycles) begin
            if (idx >= 2) bus.we_w = 1'b0;
            valid = bus.w_valid;
            data  = bus.w_data;
            last  = bus.w_last;
            if (idx == 1) begin
                checkOutput({tag, " busy at start"}, bus.rd_busy, count > 0);
                checkOutput({tag, " no early valid"}, valid, 1'b0);
            end
            if (prevStall) begin
                checkOutput({tag, " stall valid"}, valid, 1'b1);
                checkOutput({tag, " stall data"}, data, prevData);
                checkOutput({tag, " stall last"}, last, prevLast);
            end
            if (valid) begin
                if (firstValid < 0) firstValid = idx;
                checkOutput({tag, " last flag"}, last, expq.size() == 1);
            end
            if (bus.rd_done) begin
                doneCnt++;
                doneIdx = idx;
                checkOutput({tag, " busy at done"}, bus.rd_busy, 1'b0);
            end
            case (mode)
                0:       ready = 1'b1;
                1:       ready = ((idx - 1) % 3) == 0;
                default: ready = 1'($urandom_range(0, 1));
            endcase
            bus.w_ready  = ready;
            bus.rd_start = (idx == interruptIdx);
            if (idx == interruptIdx) begin
                bus.rd_base  = AW'(100);
                bus.rd_count = (AW + 1)'(5);
            end
            if (valid && ready) begin
                if (expq.size() == 0) begin
                    checkOutput({tag, " extra word"}, 1'b1, 1'b0);
                end else begin
                    expWord = expq.pop_front();
                    checkOutput({tag, " data"}, data, expWord);
                end
                hs++;
                lastHs = idx;
            end
            prevStall = valid && !ready;
            prevData  = data;
            prevLast  = last;

            if (abortAfter > 0 && hs == abortAfter) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                checkOutput({tag, " abort valid"}, bus.w_valid, 1'b0);
                checkOutput({tag, " abort last"}, bus.w_last, 1'b0);
                checkOutput({tag, " abort data"}, bus.w_data, '0);
                checkOutput({tag, " abort busy"}, bus.rd_busy, 1'b0);
                checkOutput({tag, " abort done"}, bus.rd_done, 1'b0);
                bus.w_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checkOutput({tag, " no done after abort"}, bus.rd_done, 1'b0);
                    checkOutput({tag, " idle after abort"}, bus.w_valid, 1'b0);
                end
                return;
            end
            if (doneCnt > 0 && idx >= doneIdx + 2) finished = 1'b1;
            @(posedge clk);
            @(negedge clk);
            idx++;
        end
        bus.rd_start = 1'b0;
        bus.we_w     = 1'b0;

        checkOutput({tag, " completed in bound"}, finished, 1'b1);
        checkOutput({tag, " handshakes"}, hs, count);
        checkOutput({tag, " done pulses"}, doneCnt, 1);
        if (count > 0) begin
            checkOutput({tag, " first valid cycle"}, firstValid, 2);
            checkOutput({tag, " done after last"}, doneIdx, lastHs + 1);
            if (mode == 0) checkOutput({tag, " throughput"}, lastHs, count + 1);
        end else begin
            checkOutput({tag, " never valid"}, firstValid < 0, 1'b1);
            checkOutput({tag, " zero-count done delay"}, doneIdx <= 2, 1'b1);
        end
    endtask

    initial begin
        int base, count;
        rst_n        = 1'b0;
        bus.we_w     = 1'b0;
        bus.addrw    = '0;
        bus.dw       = '0;
        bus.rd_start = 1'b0;
        bus.rd_base  = '0;
        bus.rd_count = '0;
        bus.w_ready  = 1'b0;

        #7;
        checkOutput("reset busy", bus.rd_busy, 1'b0);
        checkOutput("reset done", bus.rd_done, 1'b0);
        checkOutput("reset valid", bus.w_valid, 1'b0);
        checkOutput("reset last", bus.w_last, 1'b0);
        checkOutput("reset data", bus.w_data, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] filling RAM");
        for (int a = 0; a < DEPTH; a++) applyStimulus(a, randWord());
        for (int a = 0; a < 8; a++) applyStimulus(a, W'(a * 3));

        $display("[TB] full-rate stream");
        runStream(0, 8, 0, -1, 0, 0, "basic");

        $display("[TB] stalled stream with stray rd_start");
        runStream(0, 8, 1, 4, 0, 0, "stall");

        $display("[TB] wrap-around stream");
        for (int a = 510; a < 514; a++) applyStimulus(a % DEPTH, randWord());
        runStream(510, 4, 0, -1, 0, 0, "wrap");

        $display("[TB] zero-length request");
        runStream(37, 0, 0, -1, 0, 0, "zero");

        $display("[TB] reset mid-stream");
        runStream(0, 8, 0, -1, 3, 0, "abort");
        runStream(0, 8, 0, -1, 0, 0, "after abort");

        $display("[TB] write with rd_start, and read-during-write");
        runStream(200, 3, 0, -1, 0, 1, "write with start");
        runStream(300, 3, 0, -1, 0, 2, "read during write");

        $display("[TB] randomized streams");
        for (int t = 0; t < 4; t++) begin
            base  = $urandom_range(0, DEPTH - 1);
            count = $urandom_range(1, 24);
            for (int a = 0; a < count; a++) applyStimulus((base + a) % DEPTH, randWord());
            runStream(base, count, 2, -1, 0, 0, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
